seq_div_32: RTL and testbench
=============================

Name: seq_div_32

Overview:
- Iterative restoring divider for the datapath ALU.
- Computes the quotient and remainder of two DATA_WIDTH-bit operands, one quotient bit per clock.
- Each iteration is a trial subtraction, shift and restore, built on the ripple add/sub primitive with SnA=1.
- Sits beside the multiplier and is driven by the ALU control through a START/DONE handshake.

Parameters:
- DATA_WIDTH, 32: operand, quotient and remainder width; the iteration count equals DATA_WIDTH.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous reset, active-low.
- START  input  1  request; sampled only in IDLE.
- DVND  input  DATA_WIDTH  dividend; captured on the accepting edge.
- DVSR  input  DATA_WIDTH  divisor; captured on the accepting edge.
- BUSY  output  1  high in RUN and DONE.
- DONE  output  1  one-cycle result-valid pulse.
- QUO  output  DATA_WIDTH  quotient.
- REM  output  DATA_WIDTH  remainder.
- DBZ  output  1  divide-by-zero flag; valid while DONE=1.

Behaviour:
- Reset: RST low forces, immediately and independently of CLK, state=IDLE, count=0, BUSY=0, DONE=0, DBZ=0, QUO=0, REM=0, and clears all internal registers. Reset during RUN aborts the operation with no partial result.
- States: IDLE, RUN, DONE.
- IDLE, START=1, DVSR!=0 at edge k: latch divisor D, set R=0, Q=DVND, count=0, go to RUN.
- IDLE, START=1, DVSR=0: go to DONE at edge k+1 with QUO=all ones, REM=DVND, DBZ=1. No iterations run.
- RUN, each edge:
  - shift {R,Q} left by one;
  - compute T = R_shifted - D as a DATA_WIDTH+1-bit subtraction;
  - if there is no borrow (carry-out=1), R=T and Q[0]=1; otherwise R keeps the shifted value and Q[0]=0;
  - count increments.
- The last iteration (count=DATA_WIDTH-1) completes at edge k+DATA_WIDTH. That edge moves to DONE, and QUO/REM update with the final values.
- DONE lasts exactly one cycle (DONE=1), then returns to IDLE at the next edge.
- QUO, REM and DBZ hold their values in IDLE until the next accepted START. DBZ clears on acceptance.
- Latency for a non-zero divisor: DONE=1 in cycle k+DATA_WIDTH (32 cycles after acceptance).
- START is ignored in RUN and DONE. No queuing: a START held high through DONE is accepted again on the first IDLE cycle.
- Operands may change freely after the accepting edge.
- Width: the trial subtraction uses one guard bit so the shifted remainder never overflows; a divisor of 0x80000000 or larger is handled correctly in unsigned mode.

Optional Feature:
- Macro: SEQ_DIV_SIGNED_EN.
- When defined:
  - input port SnU (1 bit, sampled with START) is added; SnU=1 selects signed two's-complement division.
  - operands are converted to magnitudes on acceptance;
  - the quotient is negated in the DONE transition when the operand signs differ;
  - the remainder takes the sign of the dividend;
  - -2^31 / -1 yields QUO=0x80000000, REM=0 (wraparound, no flag);
  - signed divide-by-zero returns QUO=0xFFFFFFFF, REM=DVND;
  - latency is unchanged.
- When undefined: SnU does not exist and all division is unsigned.

Test Plan:
- DVND=100, DVSR=7, START at edge k -> DONE only in cycle k+32; QUO=14, REM=2, DBZ=0; BUSY high from k+1 through k+32.
- DVND=0xFFFFFFFF, DVSR=1 -> QUO=0xFFFFFFFF, REM=0.
- DVND=0xFFFFFFFF, DVSR=0x80000000 -> QUO=1, REM=0x7FFFFFFF.
- DVND=5, DVSR=0 -> DONE and DBZ=1 in cycle k+1; QUO=0xFFFFFFFF, REM=5. Next operation 9/3 -> DBZ=0, QUO=3, REM=0.
- START pulsed again at k+5 with different operands during RUN -> ignored; first result is unaffected. RST low at k+10 -> BUSY, DONE and QUO go to 0 at once, with no DONE pulse. A new START after reset completes normally.
- With SEQ_DIV_SIGNED_EN, SnU=1:
  - -7/2 -> QUO=0xFFFFFFFD, REM=0xFFFFFFFF;
  - 7/-2 -> QUO=0xFFFFFFFD, REM=1;
  - 0x80000000/0xFFFFFFFF -> QUO=0x80000000, REM=0.

Source files
------------

// File: rtl/seq_div_32.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// seq_div_32 - iterative restoring divider for the datapath ALU.
//
// Produces one quotient bit per clock: each RUN cycle shifts {R,Q} left,
// does a trial subtraction of the divisor with one guard bit, and either keeps
// the difference (quotient bit 1) or restores the shifted remainder
// (quotient bit 0). A DATA_WIDTH-bit divide takes DATA_WIDTH RUN cycles.
//
// Optional feature: define SEQ_DIV_SIGNED_EN to add the SnU input and support
// signed two's-complement division (magnitudes are divided, signs fixed up
// on the transition into DONE). Without the macro all division is unsigned.
//
// Ports:
//   CLK    in   system clock, rising edge
//   RST    in   asynchronous reset, active low
//   START  in   request, sampled only in IDLE
//   SnU    in   (SEQ_DIV_SIGNED_EN only) 1 = signed division, sampled with START
//   DVND   in   dividend, captured on the accepting edge
//   DVSR   in   divisor, captured on the accepting edge
//   BUSY   out  high in RUN and DONE
//   DONE   out  one-cycle result-valid pulse
//   QUO    out  quotient (held until the next accepted START)
//   REM    out  remainder (held until the next accepted START)
//   DBZ    out  divide-by-zero flag, valid while DONE=1
//
// Handshake: START is honoured only in IDLE; the accepting edge captures the
// operands and BUSY rises. DONE pulses for exactly one cycle with QUO/REM/DBZ
// valid, then the block returns to IDLE where a held START is taken again.
// -----------------------------------------------------------------------------
module seq_div_32 #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
`ifdef SEQ_DIV_SIGNED_EN
    input  logic                  SnU,
`endif
    input  logic [DATA_WIDTH-1:0] DVND,
    input  logic [DATA_WIDTH-1:0] DVSR,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [DATA_WIDTH-1:0] QUO,
    output logic [DATA_WIDTH-1:0] REM,
    output logic                  DBZ
);

    localparam int                CW   = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0]     LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           count_q, count_d;
    logic [DATA_WIDTH-1:0]   div_q, div_d;     // divisor magnitude
    logic [DATA_WIDTH-1:0]   rw_q, rw_d;       // working remainder R
    logic [DATA_WIDTH-1:0]   qw_q, qw_d;       // working quotient Q
    logic [DATA_WIDTH-1:0]   quo_q, quo_d;
    logic [DATA_WIDTH-1:0]   rem_q, rem_d;
    logic                    dbz_q, dbz_d;
    logic                    zdiv_q, zdiv_d;   // zero divisor: skip iterations
    logic                    negq_q, negq_d;   // negate quotient at the end
    logic                    negr_q, negr_d;   // negate remainder at the end

    logic                    signed_op;
    logic                    dvnd_neg, dvsr_neg, dvsr_zero;
    logic [DATA_WIDTH-1:0]   dvnd_mag, dvsr_mag;
    logic [DATA_WIDTH:0]     shifted;
    logic [DATA_WIDTH+1:0]   diff;
    logic                    no_borrow;
    logic [DATA_WIDTH-1:0]   r_next, q_next;

`ifdef SEQ_DIV_SIGNED_EN
    assign signed_op = SnU;
`else
    assign signed_op = 1'b0;
`endif

    assign dvnd_neg  = signed_op & DVND[DATA_WIDTH-1];
    assign dvsr_neg  = signed_op & DVSR[DATA_WIDTH-1];
    assign dvsr_zero = (DVSR == '0);
    // -2^(W-1) has no positive counterpart, but as an unsigned magnitude
    // it is exact, so the plain negate is correct for every input.
    assign dvnd_mag  = dvnd_neg ? -DVND : DVND;
    assign dvsr_mag  = dvsr_neg ? -DVSR : DVSR;

    // Shifted remainder carries the bit shifted out of R as a guard bit, so a
    // divisor with its top bit set is still compared correctly.
    assign shifted   = {rw_q, qw_q[DATA_WIDTH-1]};
    assign diff      = {1'b0, shifted} - {2'b00, div_q};
    assign no_borrow = ~diff[DATA_WIDTH+1];
    // On a borrow the shifted value is below the divisor, so its guard bit is 0.
    assign r_next    = no_borrow ? diff[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
    assign q_next    = {qw_q[DATA_WIDTH-2:0], no_borrow};

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        div_d   = div_q;
        rw_d    = rw_q;
        qw_d    = qw_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        zdiv_d  = zdiv_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d = S_RUN;
                    count_d = '0;
                    rw_d    = '0;
                    dbz_d   = 1'b0;
                    zdiv_d  = dvsr_zero;
                    div_d   = dvsr_mag;
                    // A zero divisor keeps the raw dividend to return as REM.
                    qw_d    = dvsr_zero ? DVND : dvnd_mag;
                    negq_d  = dvnd_neg ^ dvsr_neg;
                    negr_d  = dvnd_neg;
                end
            end
            S_RUN: begin
                if (zdiv_q) begin
                    state_d = S_DONE;
                    quo_d   = '1;
                    rem_d   = qw_q;
                    dbz_d   = 1'b1;
                    zdiv_d  = 1'b0;
                end else begin
                    rw_d    = r_next;
                    qw_d    = q_next;
                    count_d = count_q + CW'(1);
                    if (count_q == LAST) begin
                        state_d = S_DONE;
                        count_d = '0;
                        quo_d   = negq_q ? -q_next : q_next;
                        rem_d   = negr_q ? -r_next : r_next;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            count_q <= '0;
            div_q   <= '0;
            rw_q    <= '0;
            qw_q    <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            zdiv_q  <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            div_q   <= div_d;
            rw_q    <= rw_d;
            qw_q    <= qw_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            zdiv_q  <= zdiv_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
        end
    end

    assign BUSY = (state_q != S_IDLE);
    assign DONE = (state_q == S_DONE);
    assign QUO  = quo_q;
    assign REM  = rem_q;
    assign DBZ  = dbz_q;

endmodule

// File: tb/tb_seq_div_32.sv
`timescale 1ns/1ps
module tb_seq_div_32;
  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         START = 1'b0;
  logic [W-1:0] DVND = '0;
  logic [W-1:0] DVSR = '0;
`ifdef SEQ_DIV_SIGNED_EN
  logic         SnU = 1'b0;
`endif
  logic         BUSY, DONE, DBZ;
  logic [W-1:0] QUO, REM;

  int n_vec = 0;
  int n_err = 0;

  // clock / reset
  always #5 CLK = ~CLK;

  seq_div_32 #(.DATA_WIDTH(W)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
`ifdef SEQ_DIV_SIGNED_EN
    .SnU   (SnU),
`endif
    .DVND  (DVND),
    .DVSR  (DVSR),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .QUO   (QUO),
    .REM   (REM),
    .DBZ   (DBZ)
  );

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // reference model: plain integer arithmetic on 64-bit values
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    longint sa, sb;
    if (b == '0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = W'(sa / sb);
      r = W'(sa % sb);
      z = 1'b0;
    end else begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end
  endtask

  // driver: one full operation, optional stray START during RUN
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                        input int glitch_at, input string tag);
    logic [W-1:0] eq, er;
    logic         ez;
    int           cyc;
    bit           seen;
    logic [W-1:0] prev_quo;
    model(a, b, s, eq, er, ez);
    START = 1'b1;
    DVND  = a;
    DVSR  = b;
`ifdef SEQ_DIV_SIGNED_EN
    SnU   = s;
`endif
    @(posedge CLK); #1;
    START = 1'b0;
    DVND  = $urandom;
    DVSR  = $urandom;
    check_eq($sformatf("%s busy_on_accept", tag), W'(BUSY), W'(1));
    check_eq($sformatf("%s dbz_clear", tag), W'(DBZ), W'(0));
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 40) begin
      if (glitch_at > 0 && cyc == glitch_at) begin
        START = 1'b1;
        DVND  = $urandom;
        DVSR  = W'($urandom_range(1, 9));
      end else begin
        START = 1'b0;
      end
      @(posedge CLK); #1;
      cyc++;
      if (DONE) seen = 1;
      else check_eq($sformatf("%s busy_run", tag), W'(BUSY), W'(1));
    end
    START = 1'b0;
    check_eq($sformatf("%s latency", tag), W'(cyc), (b == '0) ? W'(1) : W'(W));
    check_eq($sformatf("%s quo", tag), QUO, eq);
    check_eq($sformatf("%s rem", tag), REM, er);
    check_eq($sformatf("%s dbz", tag), W'(DBZ), W'(ez));
    check_eq($sformatf("%s busy_done", tag), W'(BUSY), W'(1));
    prev_quo = QUO;
    @(posedge CLK); #1;
    check_eq($sformatf("%s done_pulse", tag), W'(DONE), W'(0));
    check_eq($sformatf("%s idle", tag), W'(BUSY), W'(0));
    check_eq($sformatf("%s quo_hold", tag), QUO, eq);
    check_eq($sformatf("%s rem_hold", tag), REM, er);
    if ($urandom_range(0, 1) == 1) begin
      repeat ($urandom_range(1, 3)) @(posedge CLK);
      #1;
      check_eq($sformatf("%s quo_hold_idle", tag), QUO, prev_quo);
      check_eq($sformatf("%s dbz_hold_idle", tag), W'(DBZ), W'(ez));
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    bit           rs;
    int           sel;

    // reset
    repeat (3) @(posedge CLK);
    #1;
    check_eq("rst busy", W'(BUSY), W'(0));
    check_eq("rst done", W'(DONE), W'(0));
    check_eq("rst quo", QUO, '0);
    check_eq("rst rem", REM, '0);
    check_eq("rst dbz", W'(DBZ), W'(0));
    RST = 1'b1;
    @(posedge CLK); #1;

    // directed
    run_op(32'd100, 32'd7, 1'b0, 5, "d100_7");
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0, "dmax_1");
    run_op(32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 0, "dmax_top");
    run_op(32'd5, 32'd0, 1'b0, 0, "d5_0");
    run_op(32'd9, 32'd3, 1'b0, 0, "d9_3");
    run_op(32'd0, 32'd17, 1'b0, 0, "d0_17");
    run_op(32'd6, 32'd9, 1'b0, 0, "d6_9");

    // abort in RUN: outputs clear at once, no DONE pulse
    START = 1'b1;
    DVND  = 32'd1000;
    DVSR  = 32'd3;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (9) @(posedge CLK);
    #1;
    RST = 1'b0;
    #1;
    check_eq("abort busy", W'(BUSY), W'(0));
    check_eq("abort done", W'(DONE), W'(0));
    check_eq("abort quo", QUO, '0);
    check_eq("abort rem", REM, '0);
    check_eq("abort dbz", W'(DBZ), W'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check_eq("abort no_done", W'(DONE), W'(0));
    end
    @(posedge CLK); #1;
    RST = 1'b1;
    @(negedge CLK);
    check_eq("post_abort idle", W'(BUSY), W'(0));
    @(posedge CLK); #1;
    run_op(32'd1000, 32'd3, 1'b0, 0, "post_abort");

`ifdef SEQ_DIV_SIGNED_EN
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0, "s-7_2");
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 0, "s7_-2");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, "smin_-1");
    run_op(32'hFFFF_FFF9, 32'd0, 1'b1, 0, "s-7_0");
    run_op(32'hFFFF_FFF9, 32'd2, 1'b0, 0, "u_neg7_2");
`endif

    // randomized
    for (int i = 0; i < 24; i++) begin
      ra  = $urandom;
      sel = $urandom_range(0, 3);
      case (sel)
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 255));
        2:       rb = 32'h8000_0000 | W'($urandom);
        default: rb = $urandom;
      endcase
      rs = 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      rs = ($urandom_range(0, 1) == 1);
`endif
      run_op(ra, rb, rs, (i % 5 == 0) ? int'($urandom_range(1, 20)) : 0, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
